// File: rtl/irq_controller_if.sv
// Peripheral-bus port bundle for the interrupt controller's register window.
// The CPU side drives strobes/address/data; the controller answers with combinational read data.
interface irq_controller_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: captures source rising edges, raises one IRQ to Control,
// tracks the kernel-mode service window and retires the request on an EOI write.
module irq_controller #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             pc_31,
    irq_controller_if.slave  bus,
    output logic             irq_out,
    output logic [2:0]       irq_id
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, EXIT} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] pend, mask, src_d, src_rise, pend_en, w1c, eoi_clr;
    logic             gie, act_valid;
    logic [2:0]       act_id, sel;
    logic             hit, req;
    logic [1:0]       reg_sel;
    logic             wr_pend, wr_mask, wr_ctrl, wr_eoi;
    logic             load_active, clear_active, eoi_take;
    logic             unused_wdata;

    assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[1:0] == 2'b00);
    assign reg_sel  = bus.addr[3:2];
    assign wr_pend  = bus.wr && hit && (reg_sel == 2'd0);
    assign wr_mask  = bus.wr && hit && (reg_sel == 2'd1);
    assign wr_ctrl  = bus.wr && hit && (reg_sel == 2'd2);
    assign wr_eoi   = bus.wr && hit && (reg_sel == 2'd3);
    assign unused_wdata = ^bus.wdata[31:N_SRC];

    assign src_rise = src & ~src_d;
    assign pend_en  = pend & mask;
    assign req      = gie && (|pend_en);
    assign w1c      = wr_pend ? bus.wdata[N_SRC-1:0] : '0;

    // Lowest pending-and-enabled index wins.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_en[i]) sel = 3'(i);
        end
    end

    always_comb begin
        eoi_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eoi_clr[i] = eoi_take && (act_id == 3'(i));
        end
    end

    always_comb begin
        state_nxt    = state;
        load_active  = 1'b0;
        clear_active = 1'b0;
        eoi_take     = 1'b0;
        case (state)
            IDLE: begin
                if (req && !pc_31) state_nxt = REQ;
            end
            REQ: begin
                if (pc_31) begin
                    state_nxt   = SERVICE;
                    load_active = 1'b1;
                end else if (!req) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_nxt    = EXIT;
                    eoi_take     = 1'b1;
                    clear_active = 1'b1;
                end else if (!pc_31) begin
                    // Handler left kernel mode without EOI: keep PEND so it is raised again.
                    state_nxt    = IDLE;
                    clear_active = 1'b1;
                end
            end
            EXIT: begin
                if (!pc_31) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= '0;
            mask      <= '0;
            gie       <= 1'b0;
            src_d     <= '0;
            act_valid <= 1'b0;
            act_id    <= '0;
            irq_out   <= 1'b0;
            irq_id    <= '0;
        end else begin
            state <= state_nxt;
            src_d <= src;
            // A fresh edge overrides a same-cycle W1C or EOI clear.
            pend  <= (pend & ~w1c & ~eoi_clr) | src_rise;
            if (wr_mask) mask <= bus.wdata[N_SRC-1:0];
            if (wr_ctrl) gie  <= bus.wdata[0];
            if (load_active) begin
                act_valid <= 1'b1;
                act_id    <= sel;
            end else if (clear_active) begin
                act_valid <= 1'b0;
                act_id    <= '0;
            end
            irq_out <= (state_nxt == REQ);
            if (state_nxt == REQ || load_active) irq_id <= sel;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && hit) begin
            case (reg_sel)
                2'd0:    bus.rdata = 32'(pend);
                2'd1:    bus.rdata = 32'(mask);
                2'd2:    bus.rdata = {31'b0, gie};
                default: bus.rdata = {act_valid, 28'b0, act_id};
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand sequences for reset and decode,
// then randomized traffic compared against a behavioural model.
module tb_irq_controller;
    localparam logic [31:0] BASE   = 32'h40000030;
    localparam logic [31:0] A_PEND = BASE;
    localparam logic [31:0] A_MASK = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_ACT  = BASE + 32'd12;

    localparam int P_IDLE = 0, P_RAISE = 1, P_SERV = 2, P_EXIT = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] src_r = '0;
    logic       pc_r  = 1'b0;
    logic       irq_out;
    logic [2:0] irq_id;
    int         n_checks = 0;
    int         n_err    = 0;

    irq_controller_if bus();

    irq_controller #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src_r),
        .pc_31   (pc_r),
        .bus     (bus),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  src;
        logic        pc, rd, wr;
        logic [31:0] addr, wdata, exp_rdata;
        logic        exp_irq;
        logic [2:0]  exp_id;
    } vec_t;
    vec_t vecs[$];

    // Behavioural model state
    int         m_phase;
    logic [3:0] m_pend, m_mask, m_src_d;
    logic       m_gie, m_act_v, m_irq;
    logic [2:0] m_act_id, m_id;

    task automatic model_reset();
        m_phase = P_IDLE; m_pend = '0; m_mask = '0; m_src_d = '0;
        m_gie = 1'b0; m_act_v = 1'b0; m_irq = 1'b0; m_act_id = '0; m_id = '0;
    endtask

    function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
        if (!r || a[31:4] != BASE[31:4] || a[1:0] != 2'b00) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'b0, m_pend};
            2'd1:    return {28'b0, m_mask};
            2'd2:    return {31'b0, m_gie};
            default: return {m_act_v, 28'b0, m_act_id};
        endcase
    endfunction

    task automatic model_edge(input logic [3:0] s, input logic p31, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        logic       hit, req;
        logic [1:0] off;
        logic [3:0] cand, np;
        int         first;
        hit   = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
        off   = a[3:2];
        cand  = m_pend & m_mask;
        req   = m_gie && (cand != 4'b0);
        first = 0;
        for (int i = 3; i >= 0; i--) if (cand[i]) first = i;
        np = m_pend;
        if (w && hit && off == 2'd0) np = np & ~d[3:0];
        case (m_phase)
            P_IDLE:  if (req && !p31) begin m_phase = P_RAISE; m_id = 3'(first); end
            P_RAISE: begin
                if (p31) begin
                    m_phase = P_SERV; m_act_v = 1'b1; m_act_id = 3'(first); m_id = 3'(first);
                end else if (!req) m_phase = P_IDLE;
                else m_id = 3'(first);
            end
            P_SERV: begin
                if (w && hit && off == 2'd3) begin
                    np[m_act_id[1:0]] = 1'b0;
                    m_phase = P_EXIT; m_act_v = 1'b0; m_act_id = '0;
                end else if (!p31) begin
                    m_phase = P_IDLE; m_act_v = 1'b0; m_act_id = '0;
                end
            end
            default: if (!p31) m_phase = P_IDLE;
        endcase
        m_pend = np | (s & ~m_src_d);
        if (w && hit && off == 2'd1) m_mask = d[3:0];
        if (w && hit && off == 2'd2) m_gie = d[0];
        m_src_d = s;
        m_irq   = (m_phase == P_RAISE);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        src_r = s; pc_r = p; bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d;
    endtask

    task automatic tick();
        model_edge(src_r, pc_r, bus.wr, bus.addr, bus.wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input int s, input int p, input int r, input int w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                       input int ei, input int eid);
        vec_t v;
        v.name = n; v.src = 4'(s); v.pc = 1'(p); v.rd = 1'(r); v.wr = 1'(w);
        v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_irq = 1'(ei); v.exp_id = 3'(eid);
        vecs.push_back(v);
    endtask

    task automatic step_chk(input string n, input logic ei, input logic [2:0] eid);
        tick();
        check({n, "_irq"}, 32'(irq_out), 32'(ei));
        check({n, "_id"}, 32'(irq_id), 32'(eid));
    endtask

    task automatic read_chk(input string n, input logic [31:0] a, input logic [31:0] exp);
        bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        #1;
        check(n, bus.rdata, exp);
        bus.rd = 1'b0;
    endtask

    initial begin
        //   name          src  pc rd wr addr    wdata  rdata          irq id
        add("wr_ctrl",     0,   0, 0, 1, A_CTRL, 1,     0,             0, 0);
        add("wr_mask",     0,   0, 0, 1, A_MASK, 'hF,   0,             0, 0);
        add("src2_rise",   4,   0, 1, 0, A_MASK, 0,     'hF,           0, 0);
        add("raise2",      0,   0, 1, 0, A_PEND, 0,     4,             1, 2);
        add("enter2",      0,   1, 1, 0, A_ACT,  0,     0,             0, 2);
        add("act2_rd",     0,   1, 1, 0, A_ACT,  0,     'h80000002,    0, 2);
        add("eoi2",        0,   1, 0, 1, A_ACT,  0,     0,             0, 2);
        add("pend_clr",    0,   1, 1, 0, A_PEND, 0,     0,             0, 2);
        add("act_clr",     0,   1, 1, 0, A_ACT,  0,     0,             0, 2);
        add("ret2",        0,   0, 0, 0, A_PEND, 0,     0,             0, 2);
        add("idle2",       0,   0, 0, 0, A_PEND, 0,     0,             0, 2);
        add("src31_rise",  'hA, 0, 0, 0, A_PEND, 0,     0,             0, 2);
        add("raise1",      0,   0, 1, 0, A_PEND, 0,     'hA,           1, 1);
        add("enter1",      0,   1, 0, 0, A_PEND, 0,     0,             0, 1);
        add("eoi1",        0,   1, 0, 1, A_ACT,  0,     0,             0, 1);
        add("ret1",        0,   0, 1, 0, A_PEND, 0,     8,             0, 1);
        add("raise3",      0,   0, 0, 0, A_PEND, 0,     0,             1, 3);
        add("enter3",      0,   1, 1, 0, A_ACT,  0,     0,             0, 3);
        add("eoi3",        0,   1, 0, 1, A_ACT,  0,     0,             0, 3);
        add("ret3",        0,   0, 0, 0, A_PEND, 0,     0,             0, 3);
        add("mask_e",      0,   0, 0, 1, A_MASK, 'hE,   0,             0, 3);
        add("src0_rise",   1,   0, 0, 0, A_PEND, 0,     0,             0, 3);
        add("masked",      0,   0, 1, 0, A_PEND, 0,     1,             0, 3);
        add("unmask",      0,   0, 0, 1, A_MASK, 'hF,   0,             0, 3);
        add("raise0",      0,   0, 1, 0, A_MASK, 0,     'hF,           1, 0);
        add("enter0",      0,   1, 0, 0, A_PEND, 0,     0,             0, 0);
        add("eoi0",        0,   1, 0, 1, A_ACT,  0,     0,             0, 0);
        add("ret0",        0,   0, 0, 0, A_PEND, 0,     0,             0, 0);
        add("gie_off",     0,   0, 0, 1, A_CTRL, 0,     0,             0, 0);
        add("w1c_race",    2,   0, 0, 1, A_PEND, 2,     0,             0, 0);
        add("race_rd",     2,   0, 1, 0, A_PEND, 0,     2,             0, 0);
        add("w1c",         2,   0, 0, 1, A_PEND, 2,     0,             0, 0);
        add("w1c_rd",      0,   0, 1, 0, A_PEND, 0,     0,             0, 0);
        add("gie_rd",      0,   0, 1, 0, A_CTRL, 0,     0,             0, 0);
        add("gie_on",      0,   0, 0, 1, A_CTRL, 1,     0,             0, 0);
        add("src3b",       8,   0, 0, 0, A_PEND, 0,     0,             0, 0);
        add("raise3b",     0,   0, 1, 0, A_PEND, 0,     8,             1, 3);
        add("src0b",       1,   0, 0, 0, A_PEND, 0,     0,             1, 3);
        add("preempt",     0,   0, 1, 0, A_PEND, 0,     9,             1, 0);
        add("enter0b",     0,   1, 0, 0, A_PEND, 0,     0,             0, 0);
        add("nack",        0,   0, 1, 0, A_ACT,  0,     'h80000000,    0, 0);
        add("reraise",     0,   0, 1, 0, A_PEND, 0,     9,             1, 0);
        add("enter0c",     0,   1, 0, 0, A_PEND, 0,     0,             0, 0);
        add("eoi0c",       0,   1, 0, 1, A_ACT,  0,     0,             0, 0);
        add("ret0c",       0,   0, 1, 0, A_PEND, 0,     8,             0, 0);
        add("raise3c",     0,   0, 0, 0, A_PEND, 0,     0,             1, 3);
        add("w1c3",        0,   0, 0, 1, A_PEND, 8,     0,             1, 3);
        add("withdrawn",   0,   0, 1, 0, A_PEND, 0,     0,             0, 3);

        drive(4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        #2;
        check("reset_irq", 32'(irq_out), 32'h0);
        check("reset_id", 32'(irq_id), 32'h0);
        read_chk("reset_pend", A_PEND, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].src, vecs[k].pc, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
            #1;
            check({vecs[k].name, "_rdata"}, bus.rdata, vecs[k].exp_rdata);
            tick();
            check({vecs[k].name, "_irq"}, 32'(irq_out), 32'(vecs[k].exp_irq));
            check({vecs[k].name, "_id"}, 32'(irq_id), 32'(vecs[k].exp_id));
        end

        // Reset asserted mid-service clears everything without waiting for a clock.
        drive(4'h4, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0);
        step_chk("rs_rise", 1'b0, 3'd3);
        drive(4'h0, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0);
        step_chk("rs_raise", 1'b1, 3'd2);
        drive(4'h0, 1'b1, 1'b0, 1'b0, A_PEND, 32'h0);
        step_chk("rs_enter", 1'b0, 3'd2);
        read_chk("rs_act", A_ACT, 32'h80000002);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rs_async_irq", 32'(irq_out), 32'h0);
        check("rs_async_id", 32'(irq_id), 32'h0);
        for (int k = 0; k < 4; k++) read_chk("rs_reg_zero", BASE + 32'(k * 4), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Address decode and EOI outside service.
        drive(4'h2, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0);
        step_chk("dec_rise", 1'b0, 3'd0);
        drive(4'h0, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0);
        step_chk("dec_idle", 1'b0, 3'd0);
        read_chk("dec_pend", A_PEND, 32'h2);
        read_chk("dec_above", BASE + 32'h10, 32'h0);
        read_chk("dec_unaligned", BASE + 32'h2, 32'h0);
        drive(4'h0, 1'b0, 1'b0, 1'b1, A_ACT, 32'hFFFFFFFF);
        step_chk("eoi_idle", 1'b0, 3'd0);
        drive(4'h0, 1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'hFFFFFFFF);
        step_chk("wr_unmatched", 1'b0, 3'd0);
        read_chk("eoi_idle_pend", A_PEND, 32'h2);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            src_r = src_r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) pc_r = ~pc_r;
            bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = $urandom();
            bus.addr = BASE + 32'($urandom_range(0, 3) * 4);
            case ($urandom_range(0, 7))
                0, 1: bus.rd = 1'b1;
                2: begin bus.wr = 1'b1; bus.addr = A_PEND; end
                3: begin bus.wr = 1'b1; bus.addr = A_MASK; end
                4: begin
                    bus.wr = 1'b1; bus.addr = A_CTRL;
                    bus.wdata[0] = ($urandom_range(0, 3) != 0);
                end
                5: begin bus.wr = 1'b1; bus.addr = A_ACT; end
                6: begin
                    case ($urandom_range(0, 3))
                        0: a = BASE + 32'h10;
                        1: a = BASE + 32'h1;
                        2: a = BASE - 32'h4;
                        default: a = BASE ^ 32'h80000000;
                    endcase
                    bus.addr = a;
                    bus.rd = 1'b1;
                    bus.wr = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            #1;
            check("rnd_rdata", bus.rdata, model_rdata(bus.rd, bus.addr));
            tick();
            check("rnd_irq", 32'(irq_out), 32'(m_irq));
            check("rnd_id", 32'(irq_id), 32'(m_id));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller that sequences the CPU's exception entry. It collects rising edges from up to N peripheral interrupt sources (timer, UART rx, UART tx done, switch change) and drives the single IRQ line into Control.
- It tracks service of each request across the kernel-mode window (PC[31]=1) and retires it on an end-of-interrupt (EOI) write from the handler.
- It is memory-mapped on the peripheral bus alongside Peripheral, decoded at 0x4000003x.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); index 0 has the highest priority.
- BASE_ADDR, 32'h40000030, byte address of the first register.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- src  input  N_SRC  level interrupt sources, synchronous to clk; a rising edge raises a request
- pc_31  input  1  PC[31] of the current instruction; 1 = kernel mode
- rd  input  1  bus read strobe (MemRead)
- wr  input  1  bus write strobe (MemWrite)
- addr  input  32  bus byte address (ALU_out)
- wdata  input  32  bus write data
- rdata  output  32  bus read data; combinational
- irq_out  output  1  interrupt request to Control; registered
- irq_id  output  3  id of the request being raised or serviced

Behaviour:
- Reset (reset=0, asynchronous):
  - PEND, MASK, GIE, src_d and ACTIVE are all 0; state = IDLE.
  - irq_out = 0, irq_id = 0, rdata = 0.
- Registers (word-aligned; addr[3:2] selects, full-address match required):
  - +0x0 PEND: R; W1C on bits[N_SRC-1:0].
  - +0x4 MASK: R/W.
  - +0x8 CTRL: bit0 = GIE.
  - +0xC ACTIVE: R returns {valid, 28'b0, id}; W of any value = EOI.
  - Writes take effect at posedge clk when wr=1 and the address matches.
  - rdata = selected register when rd=1 and the address matches, else 0. Unused bits read 0.
- Edge capture:
  - src_d <= src every cycle; edge = src & ~src_d.
  - PEND[i] sets at the posedge after src[i] rises.
  - If a W1C and a new edge hit the same bit in the same cycle, set wins.
  - Edges on bits with MASK=0 still pend.
- Request condition: req = GIE & |(PEND & MASK). sel = lowest index i with PEND[i]&MASK[i].
- FSM (irq_out is a registered decode of next state, so irq_out = 1 exactly while in REQ):
  - IDLE: req & ~pc_31 -> REQ; irq_id <= sel.
  - REQ:
    - pc_31 = 1 -> SERVICE; ACTIVE <= {1, sel}, and sel is frozen here.
    - ~req -> IDLE (request withdrawn by W1C, mask or GIE).
    - Otherwise irq_id tracks sel each cycle, so a higher-priority arrival pre-empts before entry.
  - SERVICE:
    - EOI write -> EXIT; PEND[ACTIVE.id] cleared in the same edge unless a new edge on that bit coincides (set wins); ACTIVE.valid <= 0.
    - pc_31 = 0 without EOI -> IDLE; ACTIVE.valid <= 0, PEND unchanged, so the request is re-raised.
  - EXIT: pc_31 = 0 -> IDLE.
  - EOI written while not in SERVICE is ignored.
- Latency:
  - src rise at edge t -> PEND at t+1 -> irq_out = 1 after edge t+2 (GIE, MASK set, user mode).
  - From pc_31 = 1, irq_out drops after the next edge.
- No nesting: while in SERVICE or EXIT, new edges only pend and are raised after return to IDLE.
- Reset mid-service returns immediately to IDLE with all state cleared.

Test Plan:
- GIE=1, MASK=4'hF, pulse src[2] -> PEND=4'b0100 one cycle later, irq_out=1 and irq_id=2 two cycles after the rise; hold pc_31=1 -> irq_out=0 next cycle, ACTIVE read = 32'h80000002.
- In SERVICE, write EOI to 0x4000003C -> PEND=0, ACTIVE=0; drop pc_31 -> IDLE; irq_out stays 0.
- src[3] and src[1] rise in the same cycle -> irq_id=1. After EOI and return -> irq_out re-asserts with irq_id=3.
- MASK=4'b1110, pulse src[0] -> PEND=4'b0001, irq_out stays 0. Write MASK=4'hF -> irq_out=1 two cycles later, irq_id=0.
- W1C 4'b0010 in the same cycle src[1] rises -> PEND[1] remains 1.
- Assert reset in SERVICE -> all registers read 0, irq_out=0 asynchronously; read PEND from an unmatched address -> rdata=0.
